dmr_retry_check: RTL and testbench
==================================

# dmr_retry_check

Dual-modular-redundant pipeline stage that sits between `retry_start` and `retry_end`. It carries each data/ID beat through two independent register copies, compares them at the output, and drives `needs_retry` into `retry_end` on disagreement so the beat is replayed from `retry_start`. It also counts flagged beats and raises a sticky fatal flag when the same beat keeps failing. Fault-injection masks let benches create mismatches deterministically.

## Interface
- `DataWidth`, 8, payload width.
- `IDSize`, 2, retry ID width; must match `retry_start`/`retry_end`.
- `CntWidth`, 16, width of the flagged-beat counter.
- `MaxRetry`, 4, consecutive flagged handshakes before `fatal_o` sets; legal range 1..255.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `data_i`  in  DataWidth  upstream data from `retry_start`.
- `id_i`  in  IDSize  upstream retry ID.
- `valid_i`  in  1  upstream valid.
- `ready_o`  out  1  upstream ready.
- `data_o`  out  DataWidth  downstream data to `retry_end`, taken from copy A.
- `id_o`  out  IDSize  downstream ID, taken from copy A.
- `needs_retry_o`  out  1  copies disagree; qualified by `valid_o`.
- `valid_o`  out  1  downstream valid.
- `ready_i`  in  1  downstream ready.
- `flip_a_i`  in  DataWidth+IDSize  XOR mask applied to {id,data} as copy A captures.
- `flip_b_i`  in  DataWidth+IDSize  XOR mask applied to {id,data} as copy B captures.
- `flag_cnt_o`  out  CntWidth  saturating count of flagged output handshakes.
- `fatal_o`  out  1  sticky: `MaxRetry` consecutive flagged handshakes.

## Operation
- State:
  - copy A = {`valid_a`, `id_a`, `data_a`}.
  - copy B = {`valid_b`, `id_b`, `data_b`}.
  - `consec` counter, 8 bits.
  - `flag_cnt`.
  - `fatal`.
- Input handshake: `valid_i & ready_o`.
- Output handshake: `valid_o & ready_i`.
- `ready_o = ~valid_a | ready_i`. Decided from copy A only.
- On input handshake, both copies load in the same cycle:
  - {`id_a`,`data_a`} <= {`id_i`,`data_i`} ^ `flip_a_i`; `valid_a` <= 1.
  - {`id_b`,`data_b`} <= {`id_i`,`data_i`} ^ `flip_b_i`; `valid_b` <= 1.
- On output handshake without a simultaneous input handshake, both valid bits clear.
- A simultaneous input and output handshake reloads both copies. The buffer stays full.
- `valid_o = valid_a | valid_b`.
- `needs_retry_o = valid_o & ((valid_a != valid_b) | (id_a != id_b) | (data_a != data_b))`.
- The stage never drops, reorders or retries beats itself. Replay is owned by `retry_start`/`retry_end`.
- On output handshake with `needs_retry_o = 1`:
  - `flag_cnt` increments, saturating at all-ones.
  - `consec` increments, saturating at 255.
  - If `consec + 1 >= MaxRetry`, `fatal` <= 1.
- On output handshake with `needs_retry_o = 0`: `consec` <= 0.
- `fatal` is sticky until reset. It does not block traffic or suppress `needs_retry_o`.
- `flag_cnt_o = flag_cnt`; `fatal_o = fatal`, both registered.

## Timing
- Reset: synchronous, active-high, on a rising edge with `rst_i = 1`. All state clears.
  - Output values during and after reset: `valid_o` 0, `needs_retry_o` 0, `ready_o` 1, `data_o`/`id_o` 0, `flag_cnt_o` 0, `fatal_o` 0.
- Reset mid-transfer discards the held beat.
- Upstream handshakes during reset are ignored. `ready_o` may be high, but nothing is stored.
- Latency: a beat accepted at edge N appears on `data_o`/`valid_o` after edge N.
- Throughput: one beat per cycle while `ready_i = 1`.
- `ready_o` depends combinationally on `ready_i`.
- Once `valid_o` is asserted, `data_o`, `id_o` and `needs_retry_o` stay stable until the output handshake.
- Flip masks are sampled only on the input-handshake edge. Changing them while holding has no effect.
- Counter and flag updates are visible one cycle after the output-handshake edge.
- `flag_cnt` at all-ones stays there.
- A flagged handshake with `consec` already 255 keeps `consec` at 255 and keeps `fatal` set.

## Test plan
- Reset, then with masks 0 push 0x3C id 1 with `ready_i = 1`.
  - Required: `valid_o` the next cycle, `data_o` 0x3C, `id_o` 1, `needs_retry_o` 0.
  - Required: `flag_cnt_o` 0, `fatal_o` 0.
- Push 0xA5 with `flip_b_i = 0x01`.
  - Required: `data_o` 0xA5 with `needs_retry_o` 1.
  - Required: after the handshake, `flag_cnt_o` 1.
  - Required: a following clean beat leaves `flag_cnt_o` at 1 and `consec` at 0.
- Hold `ready_i = 0` for 3 cycles with a beat held; change the masks during the hold.
  - Required: `ready_o` 0 throughout.
  - Required: `data_o`/`needs_retry_o` unchanged.
  - Required: beat delivered once `ready_i = 1`.
- With `MaxRetry = 4`, complete 4 consecutive handshakes with `flip_a_i = 0x100` (ID bit 0).
  - Required: `fatal_o` rises after the 4th handshake.
  - Required: a subsequent clean beat passes, and `fatal_o` stays 1.
- Continuous stream of 16 beats with `ready_i = 1` and `valid_i = 1`.
  - Required: one output per cycle, in order, with `ready_o` held 1.
- Assert `rst_i` while a flagged beat is held and `fatal_o = 1`.
  - Required: next cycle `valid_o` 0, `fatal_o` 0, `flag_cnt_o` 0, `ready_o` 1.
- Integration with `retry_start` and `retry_end` under random `flip_b_i` faults.
  - Required: the sink receives every source beat exactly once, in order.

Source files
------------

// File: rtl/dmr_retry_check.sv
// dmr_retry_check: one-deep pipeline stage holding two redundant copies of each
// beat. The copies are compared at the output, and a mismatch raises
// needs_retry_o so that the retry_end/retry_start pair replays the beat.
// The stage also counts flagged beats and sets a sticky fatal flag when
// flagged handshakes keep repeating.
module dmr_retry_check #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned IDSize    = 2,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned MaxRetry  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DataWidth-1:0]        data_i,
    input  logic [IDSize-1:0]           id_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [DataWidth-1:0]        data_o,
    output logic [IDSize-1:0]           id_o,
    output logic                        needs_retry_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    input  logic [DataWidth+IDSize-1:0] flip_a_i,
    input  logic [DataWidth+IDSize-1:0] flip_b_i,
    output logic [CntWidth-1:0]         flag_cnt_o,
    output logic                        fatal_o
);

    localparam int unsigned PayWidth   = DataWidth + IDSize;
    localparam int unsigned ConsecW    = 8;
    localparam int unsigned ConsecIncW = ConsecW + 1;

    // Redundant copies of the held beat, stored as {id, data}
    logic                  r_valid_a;
    logic                  r_valid_b;
    logic [PayWidth-1:0]   r_pay_a;
    logic [PayWidth-1:0]   r_pay_b;

    // Error bookkeeping
    logic [ConsecW-1:0]    r_consec;
    logic [CntWidth-1:0]   r_flag_cnt;
    logic                  r_fatal;

    // Combinational helpers
    logic                  w_ready;
    logic                  w_valid;
    logic                  w_mismatch;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_flag_hs;
    logic                  w_clean_hs;
    logic [PayWidth-1:0]   w_pay_in;
    logic [PayWidth-1:0]   w_load_a;
    logic [PayWidth-1:0]   w_load_b;
    logic [ConsecIncW-1:0] w_consec_inc;
    logic [ConsecW-1:0]    w_consec_next;
    logic [CntWidth-1:0]   w_flag_cnt_next;
    logic                  w_fatal_hit;

    // Handshakes, with readiness decided from copy A only
    always_comb begin
        w_ready    = ~r_valid_a | ready_i;
        w_valid    = r_valid_a | r_valid_b;
        w_mismatch = (r_valid_a != r_valid_b) | (r_pay_a != r_pay_b);
        w_in_hs    = valid_i & w_ready;
        w_out_hs   = w_valid & ready_i;
        w_flag_hs  = w_out_hs & w_mismatch;
        w_clean_hs = w_out_hs & ~w_mismatch;
    end

    // Fault masks are applied independently as each copy captures the beat
    always_comb begin
        w_pay_in = {id_i, data_i};
        w_load_a = w_pay_in ^ flip_a_i;
        w_load_b = w_pay_in ^ flip_b_i;
    end

    // Saturating next values for the consecutive and total flag counters
    always_comb begin
        w_consec_inc    = ConsecIncW'(r_consec) + ConsecIncW'(1);
        w_consec_next   = (r_consec == {ConsecW{1'b1}}) ? r_consec
                                                        : ConsecW'(w_consec_inc);
        w_flag_cnt_next = (r_flag_cnt == {CntWidth{1'b1}}) ? r_flag_cnt
                                                           : r_flag_cnt + CntWidth'(1);
        w_fatal_hit     = (w_consec_inc >= ConsecIncW'(MaxRetry));
    end

    // Copy A register: loads on input handshake, empties on a lone output handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_a <= 1'b0;
            r_pay_a   <= '0;
        end else if (w_in_hs) begin
            r_valid_a <= 1'b1;
            r_pay_a   <= w_load_a;
        end else if (w_out_hs) begin
            r_valid_a <= 1'b0;
        end
    end

    // Copy B register: same control as copy A, independent storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_b <= 1'b0;
            r_pay_b   <= '0;
        end else if (w_in_hs) begin
            r_valid_b <= 1'b1;
            r_pay_b   <= w_load_b;
        end else if (w_out_hs) begin
            r_valid_b <= 1'b0;
        end
    end

    // Consecutive-flag counter: grows on flagged handshakes, clears on clean ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_consec <= '0;
        end else if (w_flag_hs) begin
            r_consec <= w_consec_next;
        end else if (w_clean_hs) begin
            r_consec <= '0;
        end
    end

    // Total flagged-handshake counter, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flag_cnt <= '0;
        end else if (w_flag_hs) begin
            r_flag_cnt <= w_flag_cnt_next;
        end
    end

    // Sticky fatal flag: set once the retry threshold is reached, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fatal <= 1'b0;
        end else if (w_flag_hs && w_fatal_hit) begin
            r_fatal <= 1'b1;
        end
    end

    // Output mapping: the data path comes from copy A, status comes from the registers
    always_comb begin
        ready_o       = w_ready;
        valid_o       = w_valid;
        data_o        = r_pay_a[DataWidth-1:0];
        id_o          = r_pay_a[PayWidth-1:DataWidth];
        needs_retry_o = w_valid & w_mismatch;
        flag_cnt_o    = r_flag_cnt;
        fatal_o       = r_fatal;
    end

endmodule

// File: tb/tb_dmr_retry_check.sv
// Directed testbench for dmr_retry_check, including a small replay source/sink model.
module tb_dmr_retry_check;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned IDSize    = 2;
    localparam int unsigned CntWidth  = 16;
    localparam int unsigned MaxRetry  = 4;
    localparam int unsigned PayWidth  = DataWidth + IDSize;

    logic                 clk_i;
    logic                 rst_i;
    logic [DataWidth-1:0] data_i;
    logic [IDSize-1:0]    id_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [DataWidth-1:0] data_o;
    logic [IDSize-1:0]    id_o;
    logic                 needs_retry_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [PayWidth-1:0]  flip_a_i;
    logic [PayWidth-1:0]  flip_b_i;
    logic [CntWidth-1:0]  flag_cnt_o;
    logic                 fatal_o;

    int checks;
    int errors;

    dmr_retry_check #(
        .DataWidth(DataWidth),
        .IDSize   (IDSize),
        .CntWidth (CntWidth),
        .MaxRetry (MaxRetry)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .id_i         (id_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .id_o         (id_o),
        .needs_retry_o(needs_retry_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .flip_a_i     (flip_a_i),
        .flip_b_i     (flip_b_i),
        .flag_cnt_o   (flag_cnt_o),
        .fatal_o      (fatal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one beat for a single cycle, then drop valid_i and clear the masks
    task automatic push(input logic [7:0] d, input logic [1:0] id,
                        input logic [9:0] fa, input logic [9:0] fb);
        data_i   = d;
        id_i     = id;
        flip_a_i = fa;
        flip_b_i = fb;
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
        flip_a_i = '0;
        flip_b_i = '0;
        #1;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [9:0] mask;
    logic [7:0] d;
    int         sent_ok;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        data_i   = '0;
        id_i     = '0;
        flip_a_i = '0;
        flip_b_i = '0;

        // Reset, with an upstream beat offered during reset that must be ignored
        tick();
        data_i  = 8'h77;
        id_i    = 2'd2;
        valid_i = 1'b1;
        tick();
        check("rst_valid",   32'(valid_o), 32'd0);
        check("rst_ready",   32'(ready_o), 32'd1);
        check("rst_data",    32'(data_o), 32'd0);
        check("rst_id",      32'(id_o), 32'd0);
        check("rst_retry",   32'(needs_retry_o), 32'd0);
        check("rst_flagcnt", 32'(flag_cnt_o), 32'd0);
        check("rst_fatal",   32'(fatal_o), 32'd0);
        valid_i = 1'b0;
        rst_i   = 1'b0;
        tick();
        check("post_rst_valid", 32'(valid_o), 32'd0);

        // Clean beat
        push(8'h3C, 2'd1, 10'h000, 10'h000);
        check("t1_valid",   32'(valid_o), 32'd1);
        check("t1_data",    32'(data_o), 32'h3C);
        check("t1_id",      32'(id_o), 32'd1);
        check("t1_retry",   32'(needs_retry_o), 32'd0);
        check("t1_flagcnt", 32'(flag_cnt_o), 32'd0);
        check("t1_fatal",   32'(fatal_o), 32'd0);
        tick();
        check("t1_drain", 32'(valid_o), 32'd0);

        // Copy B corrupted in data bit 0
        push(8'hA5, 2'd0, 10'h000, 10'h001);
        check("t2_data",    32'(data_o), 32'hA5);
        check("t2_retry",   32'(needs_retry_o), 32'd1);
        check("t2_flagpre", 32'(flag_cnt_o), 32'd0);
        tick();
        check("t2_flagcnt", 32'(flag_cnt_o), 32'd1);
        push(8'h11, 2'd2, 10'h000, 10'h000);
        check("t2_clean_retry", 32'(needs_retry_o), 32'd0);
        tick();
        check("t2_clean_flag",   32'(flag_cnt_o), 32'd1);
        check("t2_clean_consec", 32'(dut.r_consec), 32'd0);

        // Hold with ready_i low; masks and upstream data change while the beat is held
        ready_i = 1'b0;
        push(8'h5A, 2'd3, 10'h004, 10'h000);
        valid_i  = 1'b1;
        data_i   = 8'hFF;
        id_i     = 2'd0;
        flip_a_i = 10'h3FF;
        flip_b_i = 10'h0F0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_ready", 32'(ready_o), 32'd0);
            check("t3_data",  32'(data_o), 32'h5E);
            check("t3_id",    32'(id_o), 32'd3);
            check("t3_retry", 32'(needs_retry_o), 32'd1);
            tick();
        end
        valid_i  = 1'b0;
        flip_a_i = '0;
        flip_b_i = '0;
        ready_i  = 1'b1;
        #1;
        check("t3_ready_up", 32'(ready_o), 32'd1);
        check("t3_valid",    32'(valid_o), 32'd1);
        check("t3_data_end", 32'(data_o), 32'h5E);
        tick();
        check("t3_delivered", 32'(valid_o), 32'd0);
        check("t3_flagcnt",   32'(flag_cnt_o), 32'd2);

        // Clear the consecutive count, then send 4 flagged beats with ID bit 0 flipped in copy A
        push(8'h00, 2'd0, 10'h000, 10'h000);
        tick();
        for (int k = 1; k <= 4; k++) begin
            push(8'(8'h20 + k), 2'd0, 10'h100, 10'h000);
            check("t4_retry", 32'(needs_retry_o), 32'd1);
            check("t4_id",    32'(id_o), 32'd1);
            tick();
            check("t4_fatal", 32'(fatal_o), (k >= 4) ? 32'd1 : 32'd0);
        end
        check("t4_flagcnt", 32'(flag_cnt_o), 32'd6);
        push(8'h99, 2'd2, 10'h000, 10'h000);
        check("t4_clean_retry", 32'(needs_retry_o), 32'd0);
        check("t4_clean_data",  32'(data_o), 32'h99);
        tick();
        check("t4_clean_gone", 32'(valid_o), 32'd0);
        check("t4_fatal_stay", 32'(fatal_o), 32'd1);

        // Continuous stream of 16 beats, one per cycle
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_i = 8'(8'h80 + i);
            id_i   = 2'(i % 4);
            #1;
            check("t5_ready", 32'(ready_o), 32'd1);
            tick();
            check("t5_valid", 32'(valid_o), 32'd1);
            check("t5_data",  32'(data_o), 32'(8'h80 + i));
            check("t5_id",    32'(id_o), 32'(i % 4));
        end
        valid_i = 1'b0;
        tick();
        check("t5_drain",   32'(valid_o), 32'd0);
        check("t5_flagcnt", 32'(flag_cnt_o), 32'd6);

        // Reset while a flagged beat is held and fatal is set
        ready_i = 1'b0;
        push(8'h42, 2'd1, 10'h000, 10'h001);
        check("t6_pre_retry", 32'(needs_retry_o), 32'd1);
        check("t6_pre_fatal", 32'(fatal_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("t6_valid",   32'(valid_o), 32'd0);
        check("t6_fatal",   32'(fatal_o), 32'd0);
        check("t6_flagcnt", 32'(flag_cnt_o), 32'd0);
        check("t6_ready",   32'(ready_o), 32'd1);
        check("t6_data",    32'(data_o), 32'd0);
        ready_i = 1'b1;
        tick();

        // Replay loop: the source resends each beat until the sink sees it clean
        for (int k = 0; k < 20; k++) begin
            d = 8'(k * 7 + 3);
            exp_q.push_back(d);
            sent_ok = 0;
            for (int a = 0; a < 6 && sent_ok == 0; a++) begin
                if (a < 4 && $urandom_range(0, 2) == 0)
                    mask = 10'($urandom_range(1, 1023));
                else
                    mask = '0;
                push(d, 2'(k % 4), 10'h000, mask);
                check("t7_valid", 32'(valid_o), 32'd1);
                check("t7_retry", 32'(needs_retry_o), (mask != '0) ? 32'd1 : 32'd0);
                if (valid_o && !needs_retry_o) begin
                    got_q.push_back(data_o);
                    sent_ok = 1;
                end
                tick();
            end
        end
        check("t7_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("t7_order", 32'(got_q[i]), 32'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
